// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32 control FSM with a configurable fetch wait.
// Define ILLEGAL_TRAP_EN to trap on illegal encodings; otherwise they retire as NOPs.
module mc_controller #(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [9:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [2:0] ImmSrc,
    output logic [3:0] state_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] WAIT_INIT = 4'(FETCH_WAIT);

    state_t     state;
    state_t     dec_next;
    logic       dec_illegal;
    logic [3:0] wait_cnt;
    logic       sub_sra;
    logic [9:0] alu_op;
    logic [9:0] br_op;

    always_comb begin
        dec_next    = FETCH;
        dec_illegal = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE: dec_next = MEMADR;
            OP_R:              dec_next = EXECR;
            OP_I:              dec_next = EXECI;
            OP_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) dec_illegal = 1'b1;
                else                                      dec_next    = BRANCH;
            end
            OP_JAL:            dec_next = JAL;
            OP_LUI:            dec_next = LUI;
            default:           dec_illegal = 1'b1;
        endcase
`ifdef ILLEGAL_TRAP_EN
        if (dec_illegal) dec_next = TRAP;
`else
        if (dec_illegal) dec_next = FETCH;
`endif
    end

    // Only shifts use funct7b5 in I-type; ADDI's imm[10] must never select subtract.
    assign sub_sra = (opcode == OP_R) ? funct7b5 : (funct3 == 3'b101) & funct7b5;
    assign alu_op  = {1'b0, sub_sra, 5'b0, funct3};

    always_comb begin
        case (funct3)
            3'b000:  br_op = 10'h008;
            3'b001:  br_op = 10'h009;
            3'b100:  br_op = 10'h00A;
            3'b101:  br_op = 10'h00B;
            3'b110:  br_op = 10'h00C;
            3'b111:  br_op = 10'h00D;
            default: br_op = 10'h000;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= FETCH;
            wait_cnt <= WAIT_INIT;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            // Counter reloads in every non-FETCH cycle, so it is full on FETCH entry.
            if (state != FETCH) wait_cnt <= WAIT_INIT;
            case (state)
                FETCH: begin
                    if (wait_cnt == 4'd0) state    <= DECODE;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                DECODE: begin
                    state <= dec_next;
`ifdef ILLEGAL_TRAP_EN
                    if (dec_illegal) illegal_q <= 1'b1;
`endif
                end
                MEMADR:                      state <= (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:                     state <= MEMWB;
                EXECR, EXECI, JAL, LUI:      state <= ALUWB;
                MEMWB, MEMWRITE, ALUWB, BRANCH: state <= FETCH;
                TRAP:                        state <= TRAP;
                default:                     state <= FETCH;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif
    assign state_o = state;

    always_comb begin
        case (opcode)
            OP_STORE:  ImmSrc = 3'b001;
            OP_BRANCH: ImmSrc = 3'b010;
            OP_JAL:    ImmSrc = 3'b011;
            OP_LUI:    ImmSrc = 3'b100;
            default:   ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        ALUControl = 10'h000;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (wait_cnt == 4'd0) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_op;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_op;
            end
            ALUWB:    RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = br_op;
                PCWrite    = Zero;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            LUI: begin
                ALUSrcB    = 2'b01;
                ALUControl = 10'h00E;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected outputs are queued, then compared at negedge.
module tb_mc_controller;

    typedef logic [28:0] vec_t;

    localparam logic [4:0] S_NONE  = 5'b00000;
    localparam logic [4:0] S_FETCH = 5'b10010;
    localparam logic [4:0] S_RW    = 5'b00001;
    localparam logic [4:0] S_RD    = 5'b01000;
    localparam logic [4:0] S_WR    = 5'b01100;
    localparam logic [4:0] S_PC    = 5'b10000;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;

    logic [9:0] aluc_0, aluc_2;
    logic [1:0] sa_0, sa_2, sb_0, sb_2, rs_0, rs_2;
    logic       pcw_0, pcw_2, adr_0, adr_2, mw_0, mw_2, irw_0, irw_2, rw_0, rw_2;
    logic [2:0] imm_0, imm_2;
    logic [3:0] st_0, st_2;
    logic       ill_0, ill_2;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t sb_q[$];
    vec_t exp_v, got_v;
    int   cyc;

    always #5 clk = ~clk;

    mc_controller #(.FETCH_WAIT(0)) dut0 (
        .clk(clk), .resetn(resetn), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .ALUControl(aluc_0), .ALUSrcA(sa_0), .ALUSrcB(sb_0), .ResultSrc(rs_0),
        .PCWrite(pcw_0), .AdrSrc(adr_0), .MemWrite(mw_0), .IRWrite(irw_0), .RegWrite(rw_0),
        .ImmSrc(imm_0), .state_o(st_0), .illegal_o(ill_0)
    );

    mc_controller #(.FETCH_WAIT(2)) dut2 (
        .clk(clk), .resetn(resetn), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .ALUControl(aluc_2), .ALUSrcA(sa_2), .ALUSrcB(sb_2), .ResultSrc(rs_2),
        .PCWrite(pcw_2), .AdrSrc(adr_2), .MemWrite(mw_2), .IRWrite(irw_2), .RegWrite(rw_2),
        .ImmSrc(imm_2), .state_o(st_2), .illegal_o(ill_2)
    );

    function automatic vec_t mk(input logic [3:0] st, input logic [9:0] ac, input logic [1:0] sa,
                                input logic [1:0] sb, input logic [1:0] rs, input logic [4:0] stb,
                                input logic [2:0] imm, input logic ill);
        return {st, ac, sa, sb, rs, stb, imm, ill};
    endfunction

    function automatic vec_t obs0();
        return mk(st_0, aluc_0, sa_0, sb_0, rs_0, {pcw_0, adr_0, mw_0, irw_0, rw_0}, imm_0, ill_0);
    endfunction

    function automatic vec_t obs2();
        return mk(st_2, aluc_2, sa_2, sb_2, rs_2, {pcw_2, adr_2, mw_2, irw_2, rw_2}, imm_2, ill_2);
    endfunction

    function automatic vec_t e_fetch(input logic last, input logic [2:0] imm);
        return mk(4'd0, 10'h000, 2'b00, 2'b10, 2'b10, last ? S_FETCH : S_NONE, imm, 1'b0);
    endfunction
    function automatic vec_t e_decode(input logic [2:0] imm);
        return mk(4'd1, 10'h000, 2'b01, 2'b01, 2'b00, S_NONE, imm, 1'b0);
    endfunction
    function automatic vec_t e_memadr(input logic [2:0] imm);
        return mk(4'd2, 10'h000, 2'b10, 2'b01, 2'b00, S_NONE, imm, 1'b0);
    endfunction
    function automatic vec_t e_execr(input logic [9:0] ac);
        return mk(4'd6, ac, 2'b10, 2'b00, 2'b00, S_NONE, 3'b000, 1'b0);
    endfunction
    function automatic vec_t e_execi(input logic [9:0] ac);
        return mk(4'd7, ac, 2'b10, 2'b01, 2'b00, S_NONE, 3'b000, 1'b0);
    endfunction
    function automatic vec_t e_aluwb(input logic [2:0] imm);
        return mk(4'd8, 10'h000, 2'b00, 2'b00, 2'b00, S_RW, imm, 1'b0);
    endfunction
    function automatic vec_t e_branch(input logic [9:0] ac, input logic pc);
        return mk(4'd9, ac, 2'b10, 2'b00, 2'b00, pc ? S_PC : S_NONE, 3'b010, 1'b0);
    endfunction
`ifdef ILLEGAL_TRAP_EN
    function automatic vec_t e_trap(input logic [2:0] imm);
        return mk(4'd12, 10'h000, 2'b00, 2'b00, 2'b00, S_NONE, imm, 1'b1);
    endfunction
`endif

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7b5 = f7;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #2;
        n_tests++;
        if (st_0 !== 4'd0 || st_2 !== 4'd0) begin
            n_fail++; $display("FAIL reset_state got %0d/%0d exp 0/0", st_0, st_2);
        end
        n_tests++;
        if (ill_0 !== 1'b0 || ill_2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_illegal got %b/%b exp 0/0", ill_0, ill_2);
        end
        n_tests++;
        if (mw_0 !== 1'b0 || rw_0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes got mw=%b rw=%b exp 0", mw_0, rw_0);
        end
        n_tests++;
        if (irw_2 !== 1'b0 || irw_0 !== 1'b1) begin
            n_fail++; $display("FAIL reset_fetch_wait got irw2=%b irw0=%b exp 0/1", irw_2, irw_0);
        end
    endtask

    task automatic test_rtype_sub();
        set_instr(7'b0110011, 3'b000, 1'b1);
        do_reset();
        sb_q.push_back(e_fetch(1'b1, 3'b000));
        sb_q.push_back(e_decode(3'b000));
        sb_q.push_back(e_execr(10'h100));
        sb_q.push_back(e_aluwb(3'b000));
        sb_q.push_back(e_fetch(1'b1, 3'b000));
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp_v = sb_q.pop_front(); got_v = obs0(); n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL sub cyc%0d got %h exp %h", cyc, got_v, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic test_lw_wait();
        set_instr(7'b0000011, 3'b010, 1'b0);
        do_reset();
        sb_q.push_back(e_fetch(1'b0, 3'b000));
        sb_q.push_back(e_fetch(1'b0, 3'b000));
        sb_q.push_back(e_fetch(1'b1, 3'b000));
        sb_q.push_back(e_decode(3'b000));
        sb_q.push_back(e_memadr(3'b000));
        sb_q.push_back(mk(4'd3, 10'h000, 2'b00, 2'b00, 2'b00, S_RD, 3'b000, 1'b0));
        sb_q.push_back(mk(4'd4, 10'h000, 2'b00, 2'b00, 2'b01, S_RW, 3'b000, 1'b0));
        sb_q.push_back(e_fetch(1'b0, 3'b000));
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp_v = sb_q.pop_front(); got_v = obs2(); n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL lw_wait cyc%0d got %h exp %h", cyc, got_v, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic test_branch();
        set_instr(7'b1100011, 3'b001, 1'b0);
        Zero = 1'b1;
        do_reset();
        sb_q.push_back(e_fetch(1'b1, 3'b010));
        sb_q.push_back(e_decode(3'b010));
        sb_q.push_back(e_branch(10'h009, 1'b1));
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp_v = sb_q.pop_front(); got_v = obs0(); n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL bne_taken cyc%0d got %h exp %h", cyc, got_v, exp_v);
            end
            cyc++;
        end
        Zero = 1'b0;
        sb_q.push_back(e_fetch(1'b1, 3'b010));
        sb_q.push_back(e_decode(3'b010));
        sb_q.push_back(e_branch(10'h009, 1'b0));
        sb_q.push_back(e_fetch(1'b1, 3'b010));
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp_v = sb_q.pop_front(); got_v = obs0(); n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL bne_nottaken cyc%0d got %h exp %h", cyc, got_v, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic test_alu_imm();
        set_instr(7'b0010011, 3'b101, 1'b1);
        do_reset();
        sb_q.push_back(e_fetch(1'b1, 3'b000));
        sb_q.push_back(e_decode(3'b000));
        sb_q.push_back(e_execi(10'h105));
        sb_q.push_back(e_aluwb(3'b000));
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp_v = sb_q.pop_front(); got_v = obs0(); n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL srai cyc%0d got %h exp %h", cyc, got_v, exp_v);
            end
            cyc++;
        end
        set_instr(7'b0010011, 3'b000, 1'b1);
        sb_q.push_back(e_fetch(1'b1, 3'b000));
        sb_q.push_back(e_decode(3'b000));
        sb_q.push_back(e_execi(10'h000));
        sb_q.push_back(e_aluwb(3'b000));
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp_v = sb_q.pop_front(); got_v = obs0(); n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL addi_f7 cyc%0d got %h exp %h", cyc, got_v, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic test_illegal();
        set_instr(7'b0000000, 3'b000, 1'b0);
        do_reset();
        sb_q.push_back(e_fetch(1'b1, 3'b000));
        sb_q.push_back(e_decode(3'b000));
`ifdef ILLEGAL_TRAP_EN
        repeat (3) sb_q.push_back(e_trap(3'b000));
`else
        sb_q.push_back(e_fetch(1'b1, 3'b000));
        sb_q.push_back(e_decode(3'b000));
        sb_q.push_back(e_fetch(1'b1, 3'b000));
`endif
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp_v = sb_q.pop_front(); got_v = obs0(); n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL illegal_op cyc%0d got %h exp %h", cyc, got_v, exp_v);
            end
            cyc++;
        end
        set_instr(7'b1100011, 3'b010, 1'b0);
        do_reset();
        sb_q.push_back(e_fetch(1'b1, 3'b010));
        sb_q.push_back(e_decode(3'b010));
`ifdef ILLEGAL_TRAP_EN
        sb_q.push_back(e_trap(3'b010));
`else
        sb_q.push_back(e_fetch(1'b1, 3'b010));
`endif
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp_v = sb_q.pop_front(); got_v = obs0(); n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL illegal_br cyc%0d got %h exp %h", cyc, got_v, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic test_store_reset();
        set_instr(7'b0100011, 3'b010, 1'b0);
        do_reset();
        sb_q.push_back(e_fetch(1'b1, 3'b001));
        sb_q.push_back(e_decode(3'b001));
        sb_q.push_back(e_memadr(3'b001));
        sb_q.push_back(mk(4'd5, 10'h000, 2'b00, 2'b00, 2'b00, S_WR, 3'b001, 1'b0));
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp_v = sb_q.pop_front(); got_v = obs0(); n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL sw cyc%0d got %h exp %h", cyc, got_v, exp_v);
            end
            cyc++;
        end
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if (mw_0 !== 1'b0 || adr_0 !== 1'b0) begin
            n_fail++; $display("FAIL async_abort_strobes got mw=%b adr=%b exp 0/0", mw_0, adr_0);
        end
        n_tests++;
        if (st_0 !== 4'd0) begin
            n_fail++; $display("FAIL async_abort_state got %0d exp 0", st_0);
        end
    endtask

    task automatic test_back_to_back();
        set_instr(7'b1101111, 3'b000, 1'b0);
        do_reset();
        sb_q.push_back(e_fetch(1'b1, 3'b011));
        sb_q.push_back(e_decode(3'b011));
        sb_q.push_back(mk(4'd10, 10'h000, 2'b01, 2'b10, 2'b00, S_PC, 3'b011, 1'b0));
        sb_q.push_back(e_aluwb(3'b011));
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp_v = sb_q.pop_front(); got_v = obs0(); n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL b2b_jal cyc%0d got %h exp %h", cyc, got_v, exp_v);
            end
            cyc++;
        end
        set_instr(7'b0110111, 3'b000, 1'b0);
        sb_q.push_back(e_fetch(1'b1, 3'b100));
        sb_q.push_back(e_decode(3'b100));
        sb_q.push_back(mk(4'd11, 10'h00E, 2'b00, 2'b01, 2'b00, S_NONE, 3'b100, 1'b0));
        sb_q.push_back(e_aluwb(3'b100));
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp_v = sb_q.pop_front(); got_v = obs0(); n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL b2b_lui cyc%0d got %h exp %h", cyc, got_v, exp_v);
            end
            cyc++;
        end
        set_instr(7'b1100011, 3'b000, 1'b0);
        Zero = 1'b0;
        sb_q.push_back(e_fetch(1'b1, 3'b010));
        sb_q.push_back(e_decode(3'b010));
        sb_q.push_back(e_branch(10'h008, 1'b0));
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp_v = sb_q.pop_front(); got_v = obs0(); n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL b2b_beq cyc%0d got %h exp %h", cyc, got_v, exp_v);
            end
            cyc++;
        end
        set_instr(7'b0110011, 3'b111, 1'b0);
        sb_q.push_back(e_fetch(1'b1, 3'b000));
        sb_q.push_back(e_decode(3'b000));
        sb_q.push_back(e_execr(10'h007));
        sb_q.push_back(e_aluwb(3'b000));
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp_v = sb_q.pop_front(); got_v = obs0(); n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL b2b_and cyc%0d got %h exp %h", cyc, got_v, exp_v);
            end
            cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype_sub();
        test_lw_wait();
        test_branch();
        test_alu_imm();
        test_illegal();
        test_store_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
